// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b memory-hierarchy types.
//   lc3b_word / lc3b_block   : physical byte address and cache-line data
//   pmem_arb_state_t         : pmem_arbiter FSM states (IDLE, GRANT_I, GRANT_D)
//   pmem_arb_src_t           : requester identity (SRC_I = 0, SRC_D = 1)
package lc3b_types;

   localparam int LC3B_WORD_W  = 16;
   localparam int LC3B_BLOCK_W = 128;

   typedef logic [LC3B_WORD_W-1:0]  lc3b_word;
   typedef logic [LC3B_BLOCK_W-1:0] lc3b_block;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } pmem_arb_state_t;

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } pmem_arb_src_t;

endpackage

// File: rtl/pmem_arbiter_mux.sv
// pmem_arbiter_mux: combinational steering for the shared pmem port.
//   grant_vld   : a cache currently owns the port
//   grant_src   : which cache owns it (SRC_I / SRC_D)
//   i_* / d_*   : request fields from the I-cache and D-cache
//   pmem_*      : request fields driven to physical memory (0 when no grant)
//   pmem_resp   : completion from memory, steered to the owner's resp only
module pmem_arbiter_mux
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int BLOCK_WIDTH = 128
) (
   input  logic                   grant_vld,
   input  pmem_arb_src_t          grant_src,
   input  logic                   i_pmem_read,
   input  logic                   i_pmem_write,
   input  logic [ADDR_WIDTH-1:0]  i_pmem_address,
   input  logic [BLOCK_WIDTH-1:0] i_pmem_wdata,
   input  logic                   d_pmem_read,
   input  logic                   d_pmem_write,
   input  logic [ADDR_WIDTH-1:0]  d_pmem_address,
   input  logic [BLOCK_WIDTH-1:0] d_pmem_wdata,
   input  logic                   pmem_resp,
   output logic                   pmem_read,
   output logic                   pmem_write,
   output logic [ADDR_WIDTH-1:0]  pmem_address,
   output logic [BLOCK_WIDTH-1:0] pmem_wdata,
   output logic                   i_pmem_resp,
   output logic                   d_pmem_resp
);

   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_pmem_resp  = 1'b0;
      d_pmem_resp  = 1'b0;
      if (grant_vld) begin
         if (grant_src == SRC_D) begin
            pmem_read    = d_pmem_read;
            pmem_write   = d_pmem_write;
            pmem_address = d_pmem_address;
            pmem_wdata   = d_pmem_wdata;
            d_pmem_resp  = pmem_resp;
         end else begin
            pmem_read    = i_pmem_read;
            pmem_write   = i_pmem_write;
            pmem_address = i_pmem_address;
            pmem_wdata   = i_pmem_wdata;
            i_pmem_resp  = pmem_resp;
         end
      end
   end

endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the single physical-memory port between the I-cache
// and D-cache pmem-side interfaces of the split-cache LC-3b hierarchy.
//   clk, reset_n          : clock (rising edge), async active-low reset
//   i_pmem_* / d_pmem_*   : cache-side request inputs, rdata/resp outputs
//   pmem_*                : physical memory port
// A request sampled in IDLE is granted on the next cycle; the grant is held
// until pmem_resp and is never preempted. Each response is followed by one
// IDLE cycle so the finished requester can drop its request before the next
// arbitration. Default priority is fixed, D over I.
// Optional build macro PMEM_ARBITER_RR_EN: on a tie in IDLE, grant the side
// opposite the last grant (tracked in last_grant_q).
module pmem_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int BLOCK_WIDTH = 128
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   i_pmem_read,
   input  logic                   i_pmem_write,
   input  logic [ADDR_WIDTH-1:0]  i_pmem_address,
   input  logic [BLOCK_WIDTH-1:0] i_pmem_wdata,
   output logic [BLOCK_WIDTH-1:0] i_pmem_rdata,
   output logic                   i_pmem_resp,
   input  logic                   d_pmem_read,
   input  logic                   d_pmem_write,
   input  logic [ADDR_WIDTH-1:0]  d_pmem_address,
   input  logic [BLOCK_WIDTH-1:0] d_pmem_wdata,
   output logic [BLOCK_WIDTH-1:0] d_pmem_rdata,
   output logic                   d_pmem_resp,
   output logic                   pmem_read,
   output logic                   pmem_write,
   output logic [ADDR_WIDTH-1:0]  pmem_address,
   output logic [BLOCK_WIDTH-1:0] pmem_wdata,
   input  logic [BLOCK_WIDTH-1:0] pmem_rdata,
   input  logic                   pmem_resp
);

   pmem_arb_state_t state_q;
   pmem_arb_state_t state_d;
   logic            i_req;
   logic            d_req;
   logic            grant_vld;
   pmem_arb_src_t   grant_src;

   assign i_req = i_pmem_read | i_pmem_write;
   assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARBITER_RR_EN
   pmem_arb_src_t last_grant_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= SRC_I;
      end else if (state_q == IDLE && state_d != IDLE) begin
         last_grant_q <= (state_d == GRANT_D) ? SRC_D : SRC_I;
      end
   end
`endif

   // Next-state: arbitration happens only in IDLE; a grant ends on pmem_resp.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
`ifdef PMEM_ARBITER_RR_EN
            if (d_req && i_req) begin
               state_d = (last_grant_q == SRC_D) ? GRANT_I : GRANT_D;
            end else if (d_req) begin
               state_d = GRANT_D;
            end else if (i_req) begin
               state_d = GRANT_I;
            end
`else
            if (d_req) begin
               state_d = GRANT_D;
            end else if (i_req) begin
               state_d = GRANT_I;
            end
`endif
         end
         GRANT_I, GRANT_D: begin
            if (pmem_resp) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign grant_vld = (state_q == GRANT_I) || (state_q == GRANT_D);
   assign grant_src = (state_q == GRANT_D) ? SRC_D : SRC_I;

   pmem_arbiter_mux #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .BLOCK_WIDTH (BLOCK_WIDTH)
   ) u_mux (
      .grant_vld      (grant_vld),
      .grant_src      (grant_src),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_write   (i_pmem_write),
      .i_pmem_address (i_pmem_address),
      .i_pmem_wdata   (i_pmem_wdata),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .pmem_resp      (pmem_resp),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_resp    (d_pmem_resp)
   );

   // Read data is broadcast; resp is the only qualifier. It is forced to 0
   // while reset is asserted so every output is quiet during reset.
   assign i_pmem_rdata = reset_n ? pmem_rdata : '0;
   assign d_pmem_rdata = reset_n ? pmem_rdata : '0;

   // Requester contract: a granted requester holds its request stable until
   // its resp, and never asserts read and write together.
   a_i_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (state_q == GRANT_I && !pmem_resp) |=>
         ($stable(i_pmem_read) && $stable(i_pmem_write) &&
          $stable(i_pmem_address) && $stable(i_pmem_wdata)));

   a_d_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (state_q == GRANT_D && !pmem_resp) |=>
         ($stable(d_pmem_read) && $stable(d_pmem_write) &&
          $stable(d_pmem_address) && $stable(d_pmem_wdata)));

   a_i_rw_excl: assert property (@(posedge clk) disable iff (!reset_n)
      !(i_pmem_read && i_pmem_write));

   a_d_rw_excl: assert property (@(posedge clk) disable iff (!reset_n)
      !(d_pmem_read && d_pmem_write));

endmodule
